// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative radix-2 multiply/divide engine that owns HI/LO.
// The combinational result path is fully independent of the sequential engine.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_input1,
  input  logic [WIDTH-1:0] alu_input2,
  input  logic [3:0]       aluop,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // ---------------- combinational ALU ----------------
  logic [SW-1:0] shamt;
  assign shamt = alu_input2[SW-1:0];

  always_comb begin
    alu_out = '0;
    case (aluop)
      4'd0:    alu_out = alu_input1 & alu_input2;
      4'd1:    alu_out = alu_input1 | alu_input2;
      4'd2:    alu_out = alu_input1 + alu_input2;
      4'd3:    alu_out = alu_input1 - alu_input2;
      4'd4:    alu_out = alu_input1 ^ alu_input2;
      4'd5:    alu_out = ~(alu_input1 | alu_input2);
      4'd6:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) < $signed(alu_input2))};
      4'd7:    alu_out = {{(WIDTH-1){1'b0}}, (alu_input1 < alu_input2)};
      4'd8:    alu_out = alu_input1 << shamt;
      4'd9:    alu_out = alu_input1 >> shamt;
      4'd10:   alu_out = $signed(alu_input1) >>> shamt;
      4'd11:   alu_out = {alu_input2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_out = '0;
    endcase
  end

  // ---------------- multiply/divide engine ----------------
  logic [0:0]         state_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [2*WIDTH-1:0] acc_reg;

  assign busy = (state_reg == RUN);

  // Operand magnitudes for the request presented this cycle.
  logic             signed_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign signed_op = (md_op == 3'd0) || (md_op == 3'd2);
  assign sign_a    = signed_op & alu_input1[WIDTH-1];
  assign sign_b    = signed_op & alu_input2[WIDTH-1];
  assign mag_a     = sign_a ? (-alu_input1) : alu_input1;
  assign mag_b     = sign_b ? (-alu_input2) : alu_input2;

  // Shift-add: acc holds {partial product, unconsumed multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  assign div_trial = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opb_reg};
  assign div_next  = div_trial[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign step_next = is_div_reg ? div_next : mul_next;
  assign prod_neg  = -step_next;
  assign quo       = step_next[WIDTH-1:0];
  assign rem       = step_next[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_hi = '0;
    fin_lo = '0;
    if (is_div_reg) begin
      fin_lo = neg_q_reg ? (-quo) : quo;
      fin_hi = neg_r_reg ? (-rem) : rem;
    end else begin
      fin_hi = neg_q_reg ? prod_neg[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
      fin_lo = neg_q_reg ? prod_neg[WIDTH-1:0]       : step_next[WIDTH-1:0];
    end
  end

  // A zero divisor makes every trial subtract succeed: the quotient saturates to
  // all ones and the remainder ends as |A|, which the dividend-sign fix-up turns
  // back into A. Only the quotient negate has to be suppressed for that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      count_reg  <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (md_op <= 3'd3) begin
              is_div_reg <= md_op[1];
              neg_q_reg  <= (sign_a ^ sign_b) & (alu_input2 != '0);
              neg_r_reg  <= sign_a;
              opb_reg    <= mag_b;
              acc_reg    <= {{WIDTH{1'b0}}, mag_a};
              count_reg  <= '0;
              state_reg  <= RUN;
            end else if (md_op == 3'd4) begin
              hi <= alu_input1;
            end else if (md_op == 3'd5) begin
              lo <= alu_input1;
            end
          end
        end
        RUN: begin
          acc_reg   <= step_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH-1)) begin
            hi        <= fin_hi;
            lo        <= fin_lo;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: a WIDTH=32 and a WIDTH=8 instance run against an
// arithmetic reference model, plus literal expectations for known vectors.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] in_a [2];
  logic [31:0] in_b [2];
  logic [3:0]  in_aluop [2];
  logic [2:0]  in_mdop [2];
  logic        in_start [2];

  logic [31:0] alu32, hi32, lo32;
  logic        busy32;
  logic [7:0]  alu8, hi8, lo8;
  logic        busy8;

  alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .alu_input1(in_a[0]), .alu_input2(in_b[0]),
    .aluop(in_aluop[0]), .md_op(in_mdop[0]), .start(in_start[0]),
    .alu_out(alu32), .busy(busy32), .hi(hi32), .lo(lo32)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .alu_input1(in_a[1][7:0]), .alu_input2(in_b[1][7:0]),
    .aluop(in_aluop[1]), .md_op(in_mdop[1]), .start(in_start[1]),
    .alu_out(alu8), .busy(busy8), .hi(hi8), .lo(lo8)
  );

  logic [31:0] o_alu [2];
  logic [31:0] o_hi [2];
  logic [31:0] o_lo [2];
  logic        o_busy [2];
  assign o_alu[0]  = alu32;
  assign o_alu[1]  = {24'h0, alu8};
  assign o_hi[0]   = hi32;
  assign o_hi[1]   = {24'h0, hi8};
  assign o_lo[0]   = lo32;
  assign o_lo[1]   = {24'h0, lo8};
  assign o_busy[0] = busy32;
  assign o_busy[1] = busy8;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wid(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input logic [63:0] v_in, input int w);
    logic [63:0] m;
    logic [63:0] v;
    m = mask_of(w);
    v = v_in & m;
    if (v[w-1]) v = v | ~m;
    return longint'(v);
  endfunction

  function automatic logic [31:0] alu_ref(input int w, input logic [3:0] op,
                                          input logic [31:0] a32, input logic [31:0] b32);
    logic [63:0] m, a, b, r;
    longint sa, sb;
    int sh;
    m  = mask_of(w);
    a  = {32'h0, a32} & m;
    b  = {32'h0, b32} & m;
    sa = sext(a, w);
    sb = sext(b, w);
    sh = int'(b[4:0]) & (w - 1);
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd7:  r = (a < b) ? 64'd1 : 64'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = 64'(sa >>> sh);
      4'd11: r = b << (w / 2);
      default: r = 64'd0;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  function automatic void md_ref(input int w, input logic [2:0] op,
                                 input logic [31:0] a32, input logic [31:0] b32,
                                 output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] m, a, b, p, q, r;
    longint sa, sb;
    m  = mask_of(w);
    a  = {32'h0, a32} & m;
    b  = {32'h0, b32} & m;
    sa = sext(a, w);
    sb = sext(b, w);
    p  = 64'd0;
    q  = 64'd0;
    r  = 64'd0;
    case (op)
      3'd0: begin p = 64'(sa * sb); q = p; r = p >> w; end
      3'd1: begin p = a * b;        q = p; r = p >> w; end
      3'd2: begin
        if (b == 64'd0) begin q = m; r = a; end
        else begin q = 64'(sa / sb); r = 64'(sa % sb); end
      end
      default: begin
        if (b == 64'd0) begin q = m; r = a; end
        else begin q = a / b; r = a % b; end
      end
    endcase
    q  = q & m;
    r  = r & m;
    rh = r[31:0];
    rl = q[31:0];
  endfunction

  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] p_hi [2];
  logic [31:0] p_lo [2];
  int          m_rem [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_hi[d] = '0; m_lo[d] = '0; m_rem[d] = 0; p_hi[d] = '0; p_lo[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] m32;
        logic [31:0] th, tl;
        m32 = 32'(mask_of(wid(d)));
        if (m_rem[d] > 0) begin
          m_rem[d]--;
          if (m_rem[d] == 0) begin m_hi[d] = p_hi[d]; m_lo[d] = p_lo[d]; end
        end else if (in_start[d]) begin
          if (in_mdop[d] <= 3'd3) begin
            md_ref(wid(d), in_mdop[d], in_a[d], in_b[d], th, tl);
            p_hi[d]  = th;
            p_lo[d]  = tl;
            m_rem[d] = wid(d);
          end else if (in_mdop[d] == 3'd4) m_hi[d] = in_a[d] & m32;
          else if (in_mdop[d] == 3'd5) m_lo[d] = in_a[d] & m32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("w%0d busy", wid(d)), {31'h0, o_busy[d]}, (m_rem[d] > 0) ? 32'd1 : 32'd0);
        check($sformatf("w%0d hi", wid(d)), o_hi[d], m_hi[d]);
        check($sformatf("w%0d lo", wid(d)), o_lo[d], m_lo[d]);
        check($sformatf("w%0d alu op%0d", wid(d), in_aluop[d]), o_alu[d],
              alu_ref(wid(d), in_aluop[d], in_a[d], in_b[d]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_mdop[d]  = op;
    in_a[d]     = a;
    in_b[d]     = b;
    in_start[d] = 1'b1;
    @(posedge clk); #1;
    in_start[d] = 1'b0;
    in_a[d]     = $urandom;
    in_b[d]     = $urandom;
    in_mdop[d]  = 3'($urandom);
  endtask

  task automatic wait_idle(input int d, output int cyc);
    cyc = 0;
    while (o_busy[d] && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    if (cyc >= 200) check($sformatf("w%0d busy timeout", wid(d)), 32'd1, 32'd0);
  endtask

  task automatic run(input int d, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit intrude);
    int cyc;
    issue(d, op, a, b);
    if (intrude && op <= 3'd3) begin
      repeat (3) @(posedge clk);
      #1;
      in_mdop[d]  = 3'($urandom_range(0, 5));
      in_a[d]     = $urandom;
      in_start[d] = 1'b1;
      @(posedge clk); #1;
      in_start[d] = 1'b0;
    end
    wait_idle(d, cyc);
    if (intrude && op <= 3'd3) cyc = cyc + 4;
    check($sformatf("w%0d latency op%0d", wid(d), op), 32'(cyc),
          (op <= 3'd3) ? 32'(wid(d)) : 32'd0);
    $display("w=%0d md_op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d",
             wid(d), op, a, b, o_hi[d], o_lo[d], cyc);
  endtask

  task automatic alu_chk(input int d, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    in_aluop[d] = op;
    in_a[d]     = a;
    in_b[d]     = b;
    #1;
    check($sformatf("w%0d literal alu op%0d", wid(d), op), o_alu[d], exp);
    $display("w=%0d aluop=%0d a=%h b=%h -> %h", wid(d), op, a, b, o_alu[d]);
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000 >> (32 - w);
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_a[d] = '0; in_b[d] = '0; in_aluop[d] = '0; in_mdop[d] = '0; in_start[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    en = 1'b1;

    for (int d = 0; d < 2; d++) begin
      check("reset busy", {31'h0, o_busy[d]}, 32'd0);
      check("reset hi", o_hi[d], 32'd0);
      check("reset lo", o_lo[d], 32'd0);
    end

    alu_chk(0, 4'd2,  32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_chk(0, 4'd3,  32'h0, 32'h1, 32'hFFFF_FFFF);
    alu_chk(0, 4'd6,  32'h8000_0000, 32'h1, 32'h1);
    alu_chk(0, 4'd7,  32'h8000_0000, 32'h1, 32'h0);
    alu_chk(0, 4'd10, 32'h8000_0000, 32'h4, 32'hF800_0000);
    alu_chk(0, 4'd11, 32'h0, 32'h1234, 32'h1234_0000);
    alu_chk(0, 4'd13, 32'h1234, 32'h5678, 32'h0);
    alu_chk(1, 4'd2,  32'hFF, 32'h1, 32'h0);
    alu_chk(1, 4'd10, 32'h80, 32'h4, 32'hF8);
    alu_chk(1, 4'd11, 32'h0, 32'h0C, 32'hC0);

    issue(0, 3'd0, 32'hFFFF_FFFD, 32'd7);
    cyc = 0;
    while (o_busy[0] && cyc < 200) begin cyc++; @(posedge clk); #1; end
    check("MULT busy cycles", 32'(cyc), 32'd32);
    check("MULT hi", o_hi[0], 32'hFFFF_FFFF);
    check("MULT lo", o_lo[0], 32'hFFFF_FFEB);

    run(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("MULTU hi", o_hi[0], 32'hFFFF_FFFE);
    check("MULTU lo", o_lo[0], 32'h0000_0001);
    run(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("DIV lo", o_lo[0], 32'hFFFF_FFFD);
    check("DIV hi", o_hi[0], 32'hFFFF_FFFF);
    run(0, 3'd3, 32'd7, 32'd2, 1'b0);
    check("DIVU lo", o_lo[0], 32'd3);
    check("DIVU hi", o_hi[0], 32'd1);
    run(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("DIV min lo", o_lo[0], 32'h8000_0000);
    check("DIV min hi", o_hi[0], 32'h0);
    run(0, 3'd3, 32'd5, 32'd0, 1'b0);
    check("DIVU0 lo", o_lo[0], 32'hFFFF_FFFF);
    check("DIVU0 hi", o_hi[0], 32'd5);

    // MTHI presented mid-operation must be dropped.
    issue(0, 3'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    in_mdop[0] = 3'd4; in_a[0] = 32'hAAAA; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    wait_idle(0, cyc);
    check("MTHI ignored hi", o_hi[0], 32'hFFFF_FFFF);
    check("MTHI ignored lo", o_lo[0], 32'hFFFF_FFEB);

    issue(0, 3'd5, 32'h55, 32'h0);
    check("MTLO lo", o_lo[0], 32'h55);
    check("MTLO busy", {31'h0, o_busy[0]}, 32'd0);

    issue(0, 3'd1, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort busy", {31'h0, o_busy[0]}, 32'd0);
    check("abort hi", o_hi[0], 32'd0);
    check("abort lo", o_lo[0], 32'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    run(1, 3'd0, 32'hFF, 32'hFF, 1'b0);
    check("W8 MULT hi", o_hi[1], 32'h0);
    check("W8 MULT lo", o_lo[1], 32'h1);
    run(1, 3'd2, 32'h80, 32'hFF, 1'b0);
    check("W8 DIV min lo", o_lo[1], 32'h80);
    check("W8 DIV min hi", o_hi[1], 32'h0);
    run(1, 3'd2, 32'hF9, 32'h2, 1'b0);
    check("W8 DIV lo", o_lo[1], 32'hFD);
    check("W8 DIV hi", o_hi[1], 32'hFF);
    run(1, 3'd3, 32'd5, 32'd0, 1'b0);
    check("W8 DIVU0 lo", o_lo[1], 32'hFF);
    check("W8 DIVU0 hi", o_hi[1], 32'd5);

    for (int i = 0; i < 160; i++) begin
      int d;
      d = i % 2;
      in_aluop[d] = 4'($urandom);
      run(d, 3'($urandom_range(0, 7)), pick(wid(d)), pick(wid(d)), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit for the MIPS32 pipeline. It extends the single-cycle ALU with a wider combinational operation set and an iterative multiply/divide engine that owns the HI/LO registers. The engine uses a start/busy handshake so the hazard unit can stall dependent `mfhi`/`mflo`/`mult`/`div` instructions. The combinational result path is independent of the sequential engine.

## Interface
Parameters:
- `WIDTH`, 32: datapath width in bits; must be ≥4 and even.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous reset, active-high.
- `alu_input1` input WIDTH: operand A (rs).
- `alu_input2` input WIDTH: operand B (rt or immediate).
- `aluop` input 4: combinational operation select.
- `md_op` input 3: multiply/divide operation select, sampled with `start`.
- `start` input 1: request a multiply/divide or HI/LO write this cycle.
- `alu_out` output WIDTH: combinational result.
- `busy` output 1: engine iterating; registered.
- `hi` output WIDTH: HI register; registered.
- `lo` output WIDTH: LO register; registered.

## Operation
- `alu_out` is purely combinational and is selected by `aluop`:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR.
  - 6 SLT: signed comparison, result 1 or 0, zero-extended.
  - 7 SLTU: unsigned comparison.
  - 8 SLL: A << B[log2(WIDTH)-1:0].
  - 9 SRL: logical right shift.
  - 10 SRA: arithmetic right shift.
  - 11 LUI: B << WIDTH/2.
  - 12–15 give 0.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- `md_op` encodings:
  - 0 MULT: signed; {hi,lo} = A*B, 2·WIDTH-bit product.
  - 1 MULTU: unsigned product.
  - 2 DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 3 DIVU: unsigned quotient and remainder.
  - 4 MTHI: hi ← A.
  - 5 MTLO: lo ← A.
  - 6–7: no-op.
- Engine state machine has two states, IDLE and RUN.
  - IDLE with `start`=1 and `md_op`∈0..3:
    - Latch the operands as magnitudes (signed ops take absolute values).
    - Latch the result sign and remainder sign.
    - Clear the counter and enter RUN.
  - IDLE with `start`=1 and `md_op`∈4..5: write hi/lo at that edge and stay in IDLE.
  - RUN: one radix-2 step per cycle.
    - Multiply uses shift-add.
    - Divide uses restoring shift-subtract.
    - After WIDTH steps, apply the sign fix-up (two's-complement negate where required), write hi/lo, and return to IDLE.
- `start` while in RUN is ignored entirely, including MTHI/MTLO. The hazard unit must not issue while `busy`=1.
- Divide by zero:
  - lo = all ones.
  - hi = A, the original signed dividend.
  - Latency is still WIDTH cycles.
- Signed DIV of the most-negative value by −1: lo = most-negative value, hi = 0. This falls out naturally of magnitude arithmetic.
- hi/lo hold their values between operations. Intermediate iteration values are never visible on hi/lo.

## Timing
- Reset:
  - State goes to IDLE.
  - `busy`=0, `hi`=0, `lo`=0.
  - Counter and internal operand registers are cleared.
  - Takes effect immediately, asynchronously.
- Reset mid-RUN aborts the operation. hi/lo are zeroed, not left partially updated.
- `busy` rises at the edge that samples `start` (edge E0).
- `busy` stays 1 for exactly WIDTH cycles.
- `busy` falls at edge E0+WIDTH. hi/lo take the final result at that same edge.
- A new `start` is accepted at edge E0+WIDTH+1 at the earliest, i.e. the first cycle with `busy`=0.
- MTHI/MTLO: hi/lo updated at the sampling edge; `busy` stays 0.
- `alu_out` has zero latency. It is unaffected by `busy`, `start`, or reset.
- Operands and `md_op` only need to be valid in the cycle `start`=1. They are don't-care during RUN.

## Test plan
- Reset then combinational sweep, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → 0.
  - SUB 0−1 → 0xFFFFFFFF.
  - SLT 0x80000000,1 → 1; SLTU of the same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI 0x1234 → 0x12340000.
- MULT −3 × 7:
  - `busy` high for exactly 32 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV 0x80000000 / −1 → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- `start` with MTHI 0xAAAA during RUN:
  - The request is ignored.
  - The result equals the in-flight operation.
  - MTLO 0x55 issued in IDLE → lo=0x55 next edge, `busy` stays 0.
- Assert `reset` at RUN cycle 10 → `busy`, hi, lo read 0 immediately. Repeat all checks with WIDTH=8 (MULT −1×−1 → hi=0, lo=1, latency 8).
